camera_power_off_seq: RTL and testbench

CAMERA_POWER_OFF_SEQ -- requirements
Module: camera_power_off_seq

---
 rtl/camera_pwr_pkg.sv | 20 ++
 rtl/pwr_delay_cnt.sv | 29 ++
 rtl/camera_power_off_seq.sv | 165 ++++++++++++++++
 tb/tb_camera_power_off_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pwr_pkg.sv
// Shared state encoding and default timing constants
// for the camera power-off sequencer.
package camera_pwr_pkg;

   localparam int CNT_W = 20;

   localparam logic [CNT_W-1:0] RST_TO_PWDN_DEF  = 20'd65536;
   localparam logic [CNT_W-1:0] PWDN_SETTLE_DEF  = 20'd262144;
   localparam logic [CNT_W-1:0] STOP_TIMEOUT_DEF = 20'd1048575;

   typedef enum logic [2:0] {
      IDLE,
      STOP,
      WAIT_ACK,
      RST_LOW,
      PWDN_HIGH,
      OFF
   } pwr_state_t;

endpackage

// File: rtl/pwr_delay_cnt.sv
// Shared saturating delay counter with terminal-count compare.
// Count is the number of enabled cycles since the last clear.
module pwr_delay_cnt
   import camera_pwr_pkg::*;
(
   input  logic             clk_50M,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   // tc on the last cycle of a limit-cycle wait
   assign tc = (count >= (limit - 1'b1));

endmodule

// File: rtl/camera_power_off_seq.sv
// Camera power-off sequencer: stops the stream, asserts reset,
// then power-down, and passes the power-on sequencer through when idle.
module camera_power_off_seq
   import camera_pwr_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_TO_PWDN  = RST_TO_PWDN_DEF,
   parameter logic [CNT_W-1:0] PWDN_SETTLE  = PWDN_SETTLE_DEF,
   parameter logic [CNT_W-1:0] STOP_TIMEOUT = STOP_TIMEOUT_DEF
) (
   input  logic clk_50M,
   input  logic reset_n,
   input  logic pd_req,
   input  logic up_rstn,
   input  logic up_pwnd,
   input  logic up_initial_en,
   input  logic stop_ack,
   input  logic sccb_busy,
   output logic camera1_rstn,
   output logic camera2_rstn,
   output logic camera_pwnd,
   output logic initial_en,
   output logic stop_req,
   output logic seq_rst_n,
   output logic pd_busy,
   output logic pd_done,
   output logic stop_timeout
);

   pwr_state_t state, ns;

   logic rstn_q, pwnd_q, init_q, stop_q;
   logic seq_q, busy_q, done_q, tmo_q;
   logic rstn_d, pwnd_d, init_d, stop_d;
   logic seq_d, busy_d, done_d, tmo_d;

   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_limit;

   pwr_delay_cnt u_cnt (
      .clk_50M (clk_50M),
      .reset_n (reset_n),
      .clr     (ns != state),
      .en      (cnt_en),
      .limit   (cnt_limit),
      .tc      (cnt_tc)
   );

   always_comb begin
      ns        = state;
      cnt_en    = 1'b0;
      cnt_limit = STOP_TIMEOUT;
      rstn_d    = rstn_q;
      pwnd_d    = pwnd_q;
      init_d    = 1'b0;
      stop_d    = 1'b0;
      seq_d     = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      tmo_d     = tmo_q;

      unique case (state)
         IDLE: begin
            if (pd_req) ns = STOP;
         end
         STOP: begin
            ns = WAIT_ACK;
         end
         WAIT_ACK: begin
            cnt_en = 1'b1;
            if (stop_ack && !sccb_busy) begin
               ns = RST_LOW;
            end else if (cnt_tc) begin
               ns    = RST_LOW;
               tmo_d = 1'b1;
            end
         end
         RST_LOW: begin
            cnt_en    = 1'b1;
            cnt_limit = RST_TO_PWDN;
            if (cnt_tc) ns = PWDN_HIGH;
         end
         PWDN_HIGH: begin
            cnt_en    = 1'b1;
            cnt_limit = PWDN_SETTLE;
            if (cnt_tc) ns = OFF;
         end
         OFF: begin
            if (!pd_req) ns = IDLE;
         end
         default: ns = IDLE;
      endcase

      // Outputs are registered from the state being entered
      unique case (ns)
         IDLE: begin
            rstn_d = up_rstn;
            pwnd_d = up_pwnd;
            init_d = up_initial_en;
         end
         STOP: begin
            stop_d = 1'b1;
            busy_d = 1'b1;
            tmo_d  = 1'b0;
         end
         WAIT_ACK: begin
            busy_d = 1'b1;
         end
         RST_LOW: begin
            rstn_d = 1'b0;
            pwnd_d = 1'b0;
            seq_d  = 1'b0;
            busy_d = 1'b1;
         end
         PWDN_HIGH: begin
            rstn_d = 1'b0;
            pwnd_d = 1'b1;
            seq_d  = 1'b0;
            busy_d = 1'b1;
         end
         OFF: begin
            rstn_d = 1'b0;
            pwnd_d = 1'b1;
            seq_d  = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rstn_q <= 1'b0;
         pwnd_q <= 1'b1;
         init_q <= 1'b0;
         stop_q <= 1'b0;
         seq_q  <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         state  <= ns;
         rstn_q <= rstn_d;
         pwnd_q <= pwnd_d;
         init_q <= init_d;
         stop_q <= stop_d;
         seq_q  <= seq_d;
         busy_q <= busy_d;
         done_q <= done_d;
         tmo_q  <= tmo_d;
      end
   end

   assign camera1_rstn = rstn_q;
   assign camera2_rstn = rstn_q;
   assign camera_pwnd  = pwnd_q;
   assign initial_en   = init_q;
   assign stop_req     = stop_q;
   assign seq_rst_n    = seq_q;
   assign pd_busy      = busy_q;
   assign pd_done      = done_q;
   assign stop_timeout = tmo_q;

endmodule

// File: tb/tb_camera_power_off_seq.sv
// Directed bench for camera_power_off_seq with short timing
// parameters (8 / 16 / 32 cycles).
module tb_camera_power_off_seq;

   logic clk_50M = 1'b0;
   logic reset_n;
   logic pd_req;
   logic up_rstn;
   logic up_pwnd;
   logic up_initial_en;
   logic stop_ack;
   logic sccb_busy;
   logic camera1_rstn;
   logic camera2_rstn;
   logic camera_pwnd;
   logic initial_en;
   logic stop_req;
   logic seq_rst_n;
   logic pd_busy;
   logic pd_done;
   logic stop_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk_50M = ~clk_50M;

   camera_power_off_seq #(
      .RST_TO_PWDN  (20'd8),
      .PWDN_SETTLE  (20'd16),
      .STOP_TIMEOUT (20'd32)
   ) dut (
      .clk_50M       (clk_50M),
      .reset_n       (reset_n),
      .pd_req        (pd_req),
      .up_rstn       (up_rstn),
      .up_pwnd       (up_pwnd),
      .up_initial_en (up_initial_en),
      .stop_ack      (stop_ack),
      .sccb_busy     (sccb_busy),
      .camera1_rstn  (camera1_rstn),
      .camera2_rstn  (camera2_rstn),
      .camera_pwnd   (camera_pwnd),
      .initial_en    (initial_en),
      .stop_req      (stop_req),
      .seq_rst_n     (seq_rst_n),
      .pd_busy       (pd_busy),
      .pd_done       (pd_done),
      .stop_timeout  (stop_timeout)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   // Cycle numbers count edges after pd_req is first driven.
   task automatic run_seq(input int pd_len,
                          input int ack_lo, input int ack_hi,
                          input int busy_lo, input int busy_hi,
                          output int t_stop, output int n_stop,
                          output int t_rst, output int t_pwd,
                          output int t_done, output int n_busy,
                          output int n_init);
      t_stop = 0; n_stop = 0; t_rst = 0; t_pwd = 0;
      t_done = 0; n_busy = 0; n_init = 0;
      for (int cyc = 1; cyc <= 200 && t_done == 0; cyc++) begin
         @(negedge clk_50M);
         pd_req    = (pd_len == 0) || (cyc <= pd_len);
         stop_ack  = (cyc >= ack_lo) && (cyc <= ack_hi);
         sccb_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
         tick();
         if (stop_req) begin
            n_stop++;
            if (t_stop == 0) t_stop = cyc;
         end
         if (pd_busy) n_busy++;
         if (initial_en) n_init++;
         if (!seq_rst_n && t_rst == 0) t_rst = cyc;
         if (camera_pwnd && t_rst != 0 && t_pwd == 0) t_pwd = cyc;
         if (pd_done) t_done = cyc;
      end
      @(negedge clk_50M);
      stop_ack  = 1'b0;
      sccb_busy = 1'b0;
   endtask

   task automatic release_to_idle(input string tag, input logic exp_tmo);
      @(negedge clk_50M);
      pd_req = 1'b0;
      tick();
      chk({tag, "_idle_done"}, 32'(pd_done), 0);
      chk({tag, "_idle_seq"}, 32'(seq_rst_n), 1);
      chk({tag, "_idle_rstn"}, 32'(camera1_rstn), 32'(up_rstn));
      chk({tag, "_idle_pwnd"}, 32'(camera_pwnd), 32'(up_pwnd));
      chk({tag, "_idle_tmo"}, 32'(stop_timeout), 32'(exp_tmo));
   endtask

   int t_stop, n_stop, t_rst, t_pwd, t_done, n_busy, n_init;

   initial begin
      reset_n       = 1'b0;
      pd_req        = 1'b0;
      up_rstn       = 1'b1;
      up_pwnd       = 1'b0;
      up_initial_en = 1'b1;
      stop_ack      = 1'b0;
      sccb_busy     = 1'b0;

      // Reset values, with pass-through inputs active
      tick();
      tick();
      chk("rst_rstn1", 32'(camera1_rstn), 0);
      chk("rst_rstn2", 32'(camera2_rstn), 0);
      chk("rst_pwnd", 32'(camera_pwnd), 1);
      chk("rst_init", 32'(initial_en), 0);
      chk("rst_stop", 32'(stop_req), 0);
      chk("rst_seq", 32'(seq_rst_n), 1);
      chk("rst_busy", 32'(pd_busy), 0);
      chk("rst_done", 32'(pd_done), 0);
      chk("rst_tmo", 32'(stop_timeout), 0);

      @(negedge clk_50M);
      reset_n = 1'b1;
      tick();
      chk("pass_rstn", 32'(camera1_rstn), 1);
      chk("pass_pwnd", 32'(camera_pwnd), 0);
      chk("pass_init", 32'(initial_en), 1);

      // Acknowledged stop at cycle 5, pd_req held high
      run_seq(0, 5, 5, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("ack_t_stop", t_stop, 1);
      chk("ack_n_stop", n_stop, 1);
      chk("ack_t_rst", t_rst, 5);
      chk("ack_t_pwd", t_pwd, 13);
      chk("ack_t_done", t_done, 29);
      chk("ack_n_busy", n_busy, 28);
      chk("ack_n_init", n_init, 0);
      chk("ack_tmo", 32'(stop_timeout), 0);
      tick();
      chk("off_hold_done", 32'(pd_done), 1);
      chk("off_hold_rstn", 32'(camera2_rstn), 0);
      chk("off_hold_pwnd", 32'(camera_pwnd), 1);
      chk("off_hold_busy", 32'(pd_busy), 0);
      release_to_idle("ack", 1'b0);

      // No acknowledge: timeout after 32 cycles in WAIT_ACK
      run_seq(0, 0, 0, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("tmo_t_rst", t_rst, 34);
      chk("tmo_t_pwd", t_pwd, 42);
      chk("tmo_t_done", t_done, 58);
      chk("tmo_flag", 32'(stop_timeout), 1);
      release_to_idle("tmo", 1'b1);

      // Ack held while SCCB busy through cycle 12
      run_seq(0, 3, 40, 3, 12, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("busy_t_rst", t_rst, 13);
      chk("busy_t_pwd", t_pwd, 21);
      chk("busy_t_done", t_done, 37);
      chk("busy_tmo", 32'(stop_timeout), 0);
      release_to_idle("busy", 1'b0);

      // Ack only during IDLE/STOP is ignored
      run_seq(0, 1, 2, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("early_t_rst", t_rst, 34);
      chk("early_tmo", 32'(stop_timeout), 1);
      release_to_idle("early", 1'b1);

      // Ack on the same cycle as the timeout
      run_seq(0, 34, 34, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("same_t_rst", t_rst, 34);
      chk("same_tmo", 32'(stop_timeout), 0);
      release_to_idle("same", 1'b0);

      // pd_req pulsed for 3 cycles: runs to OFF then exits
      run_seq(3, 5, 5, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("pulse_t_rst", t_rst, 5);
      chk("pulse_t_done", t_done, 29);
      tick();
      chk("pulse_exit_done", 32'(pd_done), 0);
      chk("pulse_exit_seq", 32'(seq_rst_n), 1);
      chk("pulse_exit_rstn", 32'(camera1_rstn), 1);

      // Sensor never brought up: sequence still runs in full
      @(negedge clk_50M);
      up_rstn       = 1'b0;
      up_initial_en = 1'b0;
      tick();
      chk("down_rstn", 32'(camera1_rstn), 0);
      chk("down_init", 32'(initial_en), 0);
      run_seq(0, 5, 5, 0, 0, t_stop, n_stop, t_rst, t_pwd,
              t_done, n_busy, n_init);
      chk("down_n_stop", n_stop, 1);
      chk("down_t_rst", t_rst, 5);
      chk("down_t_pwd", t_pwd, 13);
      chk("down_t_done", t_done, 29);
      up_rstn       = 1'b1;
      up_initial_en = 1'b1;
      release_to_idle("down", 1'b0);

      // Reset asserted during PWDN_HIGH
      @(negedge clk_50M);
      pd_req = 1'b1;
      repeat (4) tick();
      @(negedge clk_50M);
      stop_ack = 1'b1;
      tick();
      @(negedge clk_50M);
      stop_ack = 1'b0;
      repeat (10) tick();
      chk("pre_abort_pwnd", 32'(camera_pwnd), 1);
      chk("pre_abort_busy", 32'(pd_busy), 1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("abort_rstn", 32'(camera1_rstn), 0);
      chk("abort_pwnd", 32'(camera_pwnd), 1);
      chk("abort_busy", 32'(pd_busy), 0);
      chk("abort_seq", 32'(seq_rst_n), 1);
      pd_req = 1'b0;
      @(negedge clk_50M);
      reset_n = 1'b1;
      tick();
      chk("resume_rstn", 32'(camera1_rstn), 1);
      chk("resume_pwnd", 32'(camera_pwnd), 0);
      chk("resume_init", 32'(initial_en), 1);
      chk("resume_busy", 32'(pd_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
